// File: rtl/opcode_ram_if.sv
// Request/response bundle for opcode_ram: word/bit/byte access controls, data buses and strobes.
interface opcode_ram_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned BIT_W  = $clog2(DATA_W),
    parameter int unsigned BYTE_W = $clog2(DATA_W / 8)
) ();
    logic              WrEn;
    logic [1:0]        WrEn_Opcode;
    logic              RdEn;
    logic [1:0]        RdEn_Opcode;
    logic [ADDR_W-1:0] Addr;
    logic [BIT_W-1:0]  BitAddr;
    logic [BYTE_W-1:0] ByteAddr;
    logic [DATA_W-1:0] WrBus;
    logic [DATA_W-1:0] RdBus;
    logic              RdValid;
    logic              Busy;
    logic              Err;

    modport master (
        output WrEn, WrEn_Opcode, RdEn, RdEn_Opcode, Addr, BitAddr, ByteAddr, WrBus,
        input  RdBus, RdValid, Busy, Err
    );

    modport slave (
        input  WrEn, WrEn_Opcode, RdEn, RdEn_Opcode, Addr, BitAddr, ByteAddr, WrBus,
        output RdBus, RdValid, Busy, Err
    );
endinterface

// File: rtl/opcode_ram.sv
// Single-port RAM with opcode-selected word/bit/byte reads and writes, registered read path.
// Define MEM_CLEAR_EN to add a post-reset sweep that zeroes every word while Busy is high.
module opcode_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input logic         clk,
    input logic         reset,
    opcode_ram_if.slave bus
);
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned BIT_W  = $clog2(DATA_W);
    localparam int unsigned BYTE_W = $clog2(DATA_W / 8);

    localparam logic [1:0] OpWord    = 2'd0;
    localparam logic [1:0] OpBit     = 2'd1;
    localparam logic [1:0] OpByte    = 2'd2;
    localparam logic [1:0] OpIllegal = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              clear_wr;
    logic [ADDR_W-1:0] clear_addr;

`ifdef MEM_CLEAR_EN
    typedef enum logic [0:0] {StClear, StIdle} state_e;

    localparam logic [ADDR_W:0] LastCnt = (ADDR_W + 1)'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StClear) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
                state_d = StIdle;
            end
        end
    end

    assign busy       = (state_q == StClear);
    assign clear_wr   = busy & reset;
    assign clear_addr = cnt_q[ADDR_W-1:0];
`else
    assign busy       = 1'b0;
    assign clear_wr   = 1'b0;
    assign clear_addr = '0;
`endif

    logic accept;
    logic wr_ok;
    logic rd_ok;
    logic wr_bad;
    logic rd_bad;
    logic err_d;

    assign accept = reset & ~busy;
    assign wr_ok  = accept & bus.WrEn & (bus.WrEn_Opcode != OpIllegal);
    assign rd_ok  = accept & bus.RdEn & (bus.RdEn_Opcode != OpIllegal);
    assign wr_bad = bus.WrEn & (busy | (bus.WrEn_Opcode == OpIllegal));
    assign rd_bad = bus.RdEn & (busy | (bus.RdEn_Opcode == OpIllegal));
    assign err_d  = reset & (wr_bad | rd_bad);

    logic [BIT_W-1:0]  byte_lsb;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_sel;

    assign byte_lsb = {bus.ByteAddr, 3'b000};
    assign rd_word  = mem[bus.Addr];

    always_comb begin
        rd_sel = rd_word;
        case (bus.RdEn_Opcode)
            OpBit:   rd_sel = {{(DATA_W - 1){1'b0}}, rd_word[bus.BitAddr]};
            OpByte:  rd_sel = {{(DATA_W - 8){1'b0}}, rd_word[byte_lsb +: 8]};
            default: rd_sel = rd_word;
        endcase
    end

    // Storage has no reset; the clear sweep (when built in) takes priority over requests.
    always_ff @(posedge clk) begin
        if (clear_wr) begin
            mem[clear_addr] <= '0;
        end else if (wr_ok) begin
            case (bus.WrEn_Opcode)
                OpWord:  mem[bus.Addr]                  <= bus.WrBus;
                OpBit:   mem[bus.Addr][bus.BitAddr]     <= bus.WrBus[0];
                OpByte:  mem[bus.Addr][byte_lsb +: 8]   <= bus.WrBus[7:0];
                default: ;
            endcase
        end
    end

    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
            err_q      <= err_d;
            if (rd_ok) begin
                rd_data_q <= rd_sel;
            end
        end
    end

    assign bus.RdBus   = rd_data_q;
    assign bus.RdValid = rd_valid_q;
    assign bus.Busy    = busy;
    assign bus.Err     = err_q;
endmodule

// File: tb/tb_opcode_ram.sv
// Directed self-checking bench for opcode_ram; the sweep checks compile in when MEM_CLEAR_EN is set.
module tb_opcode_ram;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    opcode_ram_if #(.DATA_W(32), .ADDR_W(8)) bus ();

    opcode_ram #(.DATA_W(32), .ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.WrEn = 1'b0;
        bus.RdEn = 1'b0;
    endtask

    task automatic req(input logic we, input logic [1:0] wop, input logic re, input logic [1:0] rop,
                       input logic [7:0] addr, input logic [4:0] bita, input logic [1:0] bytea,
                       input logic [31:0] wdata);
        bus.WrEn        = we;
        bus.WrEn_Opcode = wop;
        bus.RdEn        = re;
        bus.RdEn_Opcode = rop;
        bus.Addr        = addr;
        bus.BitAddr     = bita;
        bus.ByteAddr    = bytea;
        bus.WrBus       = wdata;
        cycle();
        idle();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.Busy === 1'b1 && n < 1000) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b0;
        idle();
        bus.WrEn_Opcode = 2'd0;
        bus.RdEn_Opcode = 2'd0;
        bus.Addr        = '0;
        bus.BitAddr     = '0;
        bus.ByteAddr    = '0;
        bus.WrBus       = '0;

        // Requests during reset must be ignored.
        cycle();
        bus.RdEn = 1'b1;
        cycle();
        idle();
        check("rst_rdbus", bus.RdBus, 32'h0);
        check("rst_rdvalid", {31'b0, bus.RdValid}, 32'h0);
        check("rst_err", {31'b0, bus.Err}, 32'h0);
`ifdef MEM_CLEAR_EN
        check("rst_busy", {31'b0, bus.Busy}, 32'h1);
        reset = 1'b1;
        count_busy(n);
        check("sweep_len", n, 32'd256);
        for (int i = 0; i < 256; i++) begin
            req(1'b0, 2'd0, 1'b1, 2'd0, 8'(i), 5'd0, 2'd0, 32'h0);
            if (bus.RdBus !== 32'h0 || bus.RdValid !== 1'b1) begin
                check("sweep_rd_data", bus.RdBus, 32'h0);
                check("sweep_rd_valid", {31'b0, bus.RdValid}, 32'h1);
            end else begin
                total++;
            end
        end
`else
        check("rst_busy", {31'b0, bus.Busy}, 32'h0);
        reset = 1'b1;
        cycle();
        check("busy_after_rst", {31'b0, bus.Busy}, 32'h0);
`endif

        // Sub-word writes; upper WrBus bits must be ignored for bit/byte ops.
        req(1'b1, 2'd0, 1'b0, 2'd0, 8'h10, 5'd0, 2'd0, 32'hA5A5A5A5);
        check("wr_no_valid", {31'b0, bus.RdValid}, 32'h0);
        req(1'b1, 2'd2, 1'b0, 2'd0, 8'h10, 5'd0, 2'd2, 32'hFFFFFF3C);
        req(1'b1, 2'd1, 1'b0, 2'd0, 8'h10, 5'd0, 2'd0, 32'hFFFFFFFE);
        req(1'b0, 2'd0, 1'b1, 2'd0, 8'h10, 5'd0, 2'd0, 32'h0);
        check("subword_word", bus.RdBus, 32'hA53CA5A4);
        check("subword_valid", {31'b0, bus.RdValid}, 32'h1);

        // Read modes, back to back: RdValid stays high.
        req(1'b0, 2'd0, 1'b1, 2'd1, 8'h10, 5'd31, 2'd0, 32'h0);
        check("bit31", bus.RdBus, 32'h00000001);
        check("b2b_valid", {31'b0, bus.RdValid}, 32'h1);
        req(1'b0, 2'd0, 1'b1, 2'd1, 8'h10, 5'd0, 2'd0, 32'h0);
        check("bit0", bus.RdBus, 32'h00000000);
        req(1'b0, 2'd0, 1'b1, 2'd2, 8'h10, 5'd0, 2'd3, 32'h0);
        check("byte3", bus.RdBus, 32'h000000A5);
        req(1'b0, 2'd0, 1'b1, 2'd2, 8'h10, 5'd0, 2'd2, 32'h0);
        check("byte2", bus.RdBus, 32'h0000003C);
        req(1'b0, 2'd0, 1'b1, 2'd2, 8'h10, 5'd0, 2'd0, 32'h0);
        check("byte0", bus.RdBus, 32'h000000A4);

        // Idle: valid drops, data holds.
        cycle();
        check("idle_valid", {31'b0, bus.RdValid}, 32'h0);
        check("idle_hold", bus.RdBus, 32'h000000A4);

        // Simultaneous write/read at one address returns old data.
        req(1'b1, 2'd0, 1'b0, 2'd0, 8'h20, 5'd0, 2'd0, 32'h11111111);
        req(1'b1, 2'd0, 1'b1, 2'd0, 8'h20, 5'd0, 2'd0, 32'h22222222);
        check("rw_old", bus.RdBus, 32'h11111111);
        check("rw_valid", {31'b0, bus.RdValid}, 32'h1);
        req(1'b0, 2'd0, 1'b1, 2'd0, 8'h20, 5'd0, 2'd0, 32'h0);
        check("rw_new", bus.RdBus, 32'h22222222);

        // Illegal read opcode.
        req(1'b0, 2'd0, 1'b1, 2'd3, 8'h10, 5'd0, 2'd0, 32'h0);
        check("ill_rd_err", {31'b0, bus.Err}, 32'h1);
        check("ill_rd_valid", {31'b0, bus.RdValid}, 32'h0);
        check("ill_rd_hold", bus.RdBus, 32'h22222222);
        cycle();
        check("err_one_cycle", {31'b0, bus.Err}, 32'h0);

        // Illegal write opcode, with a legal read in the same cycle.
        req(1'b1, 2'd0, 1'b0, 2'd0, 8'h30, 5'd0, 2'd0, 32'h00000000);
        check("legal_no_err", {31'b0, bus.Err}, 32'h0);
        req(1'b1, 2'd3, 1'b1, 2'd0, 8'h30, 5'd0, 2'd0, 32'hFFFFFFFF);
        check("ill_wr_err", {31'b0, bus.Err}, 32'h1);
        check("ill_wr_comp_valid", {31'b0, bus.RdValid}, 32'h1);
        check("ill_wr_comp_data", bus.RdBus, 32'h00000000);
        req(1'b0, 2'd0, 1'b1, 2'd0, 8'h30, 5'd0, 2'd0, 32'h0);
        check("ill_wr_dropped", bus.RdBus, 32'h00000000);
        check("ill_wr_err_clr", {31'b0, bus.Err}, 32'h0);
        req(1'b0, 2'd0, 1'b1, 2'd0, 8'h10, 5'd0, 2'd0, 32'h0);
        check("addr10_intact", bus.RdBus, 32'hA53CA5A4);

`ifdef MEM_CLEAR_EN
        // Second sweep, request while Busy, then reset at count 100.
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        for (int i = 0; i < 50; i++) cycle();
        req(1'b0, 2'd0, 1'b1, 2'd0, 8'h10, 5'd0, 2'd0, 32'h0);
        check("busy_req_err", {31'b0, bus.Err}, 32'h1);
        check("busy_req_valid", {31'b0, bus.RdValid}, 32'h0);
        for (int i = 0; i < 49; i++) cycle();
        reset = 1'b0;
        cycle();
        check("mid_busy", {31'b0, bus.Busy}, 32'h1);
        check("mid_rdbus", bus.RdBus, 32'h0);
        check("mid_rdvalid", {31'b0, bus.RdValid}, 32'h0);
        cycle();
        reset = 1'b1;
        count_busy(n);
        check("resweep_len", n, 32'd256);
        req(1'b0, 2'd0, 1'b1, 2'd0, 8'h10, 5'd0, 2'd0, 32'h0);
        check("resweep_zero", bus.RdBus, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/opcode_ram.md
# opcode_ram

Parametrised single-port synchronous RAM with opcode-selected word, bit and byte access on both read and write. It extends the team's 256 x 32 opcode memory with:
- configurable data width and depth
- sub-word writes
- a registered read path with a valid strobe
- an error strobe for illegal requests
- an optional post-reset clear sweep

It sits as the local data store behind the lab datapath and register-file blocks.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8 and ≥ 16
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
- BIT_W, $clog2(DATA_W), derived; width of BitAddr
- BYTE_W, $clog2(DATA_W/8), derived; width of ByteAddr

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset, sampled on rising clk
- WrEn  in  1  write request
- WrEn_Opcode  in  2  write mode: 0 word, 1 bit, 2 byte, 3 illegal
- RdEn  in  1  read request
- RdEn_Opcode  in  2  read mode: 0 word, 1 bit, 2 byte, 3 illegal
- Addr  in  ADDR_W  word address, shared by read and write
- BitAddr  in  BIT_W  bit index within word, for opcode 1
- ByteAddr  in  BYTE_W  byte index within word, for opcode 2
- WrBus  in  DATA_W  write data
- RdBus  out  DATA_W  registered read data
- RdValid  out  1  one-cycle strobe, RdBus updated this cycle
- Busy  out  1  clear sweep in progress; requests are not accepted
- Err  out  1  one-cycle strobe for a rejected request

## Operation
- Requests are sampled on each rising clk while reset is high and Busy is low.
- Word write: mem[Addr] <= WrBus.
- Bit write: mem[Addr][BitAddr] <= WrBus[0]; the other bits are unchanged.
- Byte write: mem[Addr][ByteAddr*8 +: 8] <= WrBus[7:0]; the other bytes are unchanged.
- Word read: RdBus <= mem[Addr].
- Bit read: RdBus <= {zeros, mem[Addr][BitAddr]}.
- Byte read: RdBus <= {zeros, mem[Addr][ByteAddr*8 +: 8]}.
- WrEn and RdEn may both be set in one cycle.
  - Both execute.
  - The read returns the pre-write contents, including at the same Addr.
- An illegal opcode (3) on an asserted enable is handled as follows:
  - That operation is dropped.
  - Err pulses.
  - A legal companion operation in the same cycle still executes.
- A request while Busy is dropped and Err pulses.
- With both WrEn and RdEn low, nothing changes; RdBus holds its last value.

## Timing
- Outputs during reset (reset low): RdBus = 0, RdValid = 0, Err = 0, Busy = 1 (with MEM_CLEAR_EN) or 0 (without).
- Read latency is 1 cycle.
  - RdEn sampled at edge N gives RdBus and RdValid = 1 after edge N.
  - RdValid falls after edge N+1 unless another read is sampled.
- Write latency: data is visible to a read sampled at edge N+1 or later.
- Err is registered; it is high for exactly the cycle after the offending edge.
- Back-to-back reads every cycle give RdValid continuously high.
- Clear FSM (MEM_CLEAR_EN only) has states CLEAR and IDLE.
  - Reset low forces CLEAR, sets cnt = 0 and sets Busy = 1.
  - In CLEAR with reset high, each edge writes 0 to mem[cnt] and increments cnt.
  - After the write at cnt = DEPTH-1, the FSM moves to IDLE and Busy falls.
  - Busy is therefore high for exactly DEPTH cycles after reset releases.
  - Reset asserted mid-sweep restarts the sweep at cnt = 0.
  - cnt is ADDR_W+1 bits wide, so no wrap occurs before termination.

## Configuration
- MEM_CLEAR_EN defined: the clear FSM is present and the behaviour above applies.
- MEM_CLEAR_EN undefined: no FSM, Busy is tied 0, memory contents after reset are undefined (X), and requests are accepted from the first cycle after reset releases.

## Test plan
- Clear sweep, with MEM_CLEAR_EN and default parameters: hold reset low 2 cycles, then release. Busy must stay high for exactly 256 cycles. Word-reading all 256 addresses afterwards must return 0x00000000 with RdValid high each following cycle.
- Sub-word write: word-write 0xA5A5A5A5 to Addr 0x10, byte-write 0x3C at ByteAddr 2, then bit-write 0 at BitAddr 0. A word read must return 0xA53CA5A4.
- Read modes on Addr 0x10 (holding 0xA53CA5A4):
  - bit read, BitAddr 31 → RdBus = 0x00000001
  - byte read, ByteAddr 3 → RdBus = 0x000000A5
- Simultaneous access: Addr 0x20 holds 0x11111111. Assert WrEn (word, 0x22222222) and RdEn (word) at Addr 0x20 in one cycle. RdBus must be 0x11111111; the next read must return 0x22222222.
- Illegal request: RdEn with RdEn_Opcode = 3 must give Err for 1 cycle, RdValid = 0 and RdBus unchanged. WrEn with opcode 3 at Addr 0x30 must give Err, and a following read of 0x30 must return 0.
- Reset mid-operation: assert reset at sweep count 100. Busy must stay high. After release, Busy must stay high for a further 256 cycles, and RdBus and RdValid must be 0 during reset.
